// File: rtl/fsm_gen.sv
// Step-forward/step-back state sequencer with per-state minimum dwell and wrap flag.
// Define FSM_GEN_GRAY_OUT_EN to present state_out as the Gray code of the index.
module fsm_gen #(
  parameter int STATE_W    = 4,
  parameter int NUM_STATES = 16,
  parameter int DWELL      = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               input1,
  input  logic               input2,
  output logic [STATE_W-1:0] state_out,
  output logic               dwell_done,
  output logic               wrap_pulse
);

  typedef enum logic [1:0] {
    CMD_HOLD    = 2'b00,
    CMD_BACK    = 2'b01,
    CMD_FWD     = 2'b10,
    CMD_RESTART = 2'b11
  } cmd_e;

  localparam int                 CNT_W    = 8;
  localparam logic [STATE_W-1:0] LAST_IDX = STATE_W'(NUM_STATES - 1);
  localparam logic [STATE_W:0]   NUM_IDX  = (STATE_W + 1)'(NUM_STATES);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(DWELL - 1);

  logic [STATE_W-1:0] idx;
  logic [CNT_W-1:0]   cnt;
  logic               illegal;
  cmd_e               cmd;

  assign cmd        = cmd_e'({input1, input2});
  assign dwell_done = (cnt == CNT_MAX);
  // Only reachable when NUM_STATES leaves unused encodings (e.g. after an upset).
  assign illegal    = ({1'b0, idx} >= NUM_IDX);

  // NOTE: all state here is non-blocking so every register sees pre-edge values;
  // wrap_pulse defaults low and is overridden only on a wrapping step.
  always_ff @(posedge clk) begin
    wrap_pulse <= 1'b0;
    if (reset || illegal) begin
      idx <= '0;
      cnt <= '0;
    end else begin
      unique case (cmd)
        CMD_RESTART: begin
          idx <= '0;
          cnt <= '0;
        end
        CMD_FWD: begin
          if (dwell_done) begin
            cnt <= '0;
            if (idx == LAST_IDX) begin
              idx        <= '0;
              wrap_pulse <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CMD_BACK: begin
          if (dwell_done) begin
            cnt <= '0;
            if (idx == '0) begin
              idx        <= LAST_IDX;
              wrap_pulse <= 1'b1;
            end else begin
              idx <= idx - 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CMD_HOLD: begin
          if (!dwell_done) cnt <= cnt + 1'b1;
        end
      endcase
    end
  end

`ifdef FSM_GEN_GRAY_OUT_EN
  assign state_out = idx ^ (idx >> 1);
`else
  assign state_out = idx;
`endif

endmodule

// File: doc/fsm_gen.md
FSM_GEN -- requirements
Module: fsm_gen

Interface
REQ-001 SHALL have parameter STATE_W, default 4, width of state_out.
REQ-002 SHALL have parameter NUM_STATES, default 16, number of legal states (2..2^STATE_W).
REQ-003 SHALL have parameter DWELL, default 1, minimum cycles in a state before a step is allowed (1..255).
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port input1, input, 1, step-forward request.
REQ-007 SHALL have port input2, input, 1, step-back request.
REQ-008 SHALL have port state_out, output, STATE_W, current state encoding.
REQ-009 SHALL have port dwell_done, output, 1, high when the current state may step on this edge.
REQ-010 SHALL have port wrap_pulse, output, 1, one-cycle flag on a wrap-around step.

Function
REQ-011 SHALL hold an internal state index idx (0..NUM_STATES-1) and a dwell counter cnt (0..DWELL-1), both registered.
REQ-012 SHALL drive dwell_done = (cnt == DWELL-1), combinational from registers; constant 1 when DWELL=1.
REQ-013 SHALL decode {input1,input2} each edge: 00 hold; 10 forward; 01 back; 11 restart.
REQ-014 SHALL, on forward with dwell_done=1: idx+1, or 0 from NUM_STATES-1 (wrap).
REQ-015 SHALL, on back with dwell_done=1: idx-1, or NUM_STATES-1 from 0 (wrap).
REQ-016 SHALL ignore forward/back while dwell_done=0; idx holds and cnt increments.
REQ-017 SHALL, on restart (11), set idx=0 and cnt=0 on that edge regardless of dwell_done; restart from idx 0 is not a wrap.
REQ-018 SHALL clear cnt to 0 on every edge where idx changes (step, wrap or restart).
REQ-019 SHALL, on edges where idx does not change, increment cnt, saturating at DWELL-1.
REQ-020 SHALL register wrap_pulse=1 for exactly the cycle in which state_out first shows the wrapped value; 0 otherwise.
REQ-021 SHALL update state_out one cycle after the sampling edge (registered output, latency 1).
REQ-022 SHALL force idx=0, cnt=0 on the next edge if idx is ever >= NUM_STATES (illegal-state recovery), no wrap_pulse.

Reset
REQ-023 SHALL, while reset=1 at an edge, set idx=0, cnt=0, wrap_pulse=0, overriding all inputs.
REQ-024 SHALL present state_out=encoding of 0 and dwell_done=(DWELL==1) the cycle after reset.
REQ-025 SHALL abort any partially elapsed dwell when reset asserts mid-operation; no step retained.

Configuration
REQ-026 SHALL, when macro FSM_GEN_GRAY_OUT_EN is defined, drive state_out = idx ^ (idx >> 1) (Gray code of idx).
REQ-027 SHALL, when FSM_GEN_GRAY_OUT_EN is undefined, drive state_out = idx in plain binary; all other behaviour identical.

Verification
REQ-028 SHALL cover defaults, binary: reset, then input1=1,input2=0 for 17 cycles -> state_out 1,2,...,15,0,1; wrap_pulse high only with the 0.
REQ-029 SHALL cover back-wrap: reset, then 01 for one cycle -> state_out=15, wrap_pulse=1; next cycle 00 -> state_out=15, wrap_pulse=0.
REQ-030 SHALL cover dwell: DWELL=3, reset, hold 10 -> state_out steps 0->1 after 3 edges, then every 3 edges; dwell_done high one cycle in three.
REQ-031 SHALL cover restart: from state 9 with DWELL=3 mid-dwell, apply 11 -> next cycle state_out=0, wrap_pulse=0, cnt=0.
REQ-032 SHALL cover NUM_STATES=10, Gray on: forward from 9 -> state_out=0000 with wrap_pulse=1; idx 5 shows 0111.
REQ-033 SHALL cover reset mid-dwell: DWELL=4, assert reset at cnt=2 -> state_out=0, dwell_done=0, next step only after 4 edges.
